// File: rtl/bitty_fetch_sequencer.sv
// Program counter and instruction fetch sequencer that steps the Bitty core through its
// load/calc/store handshake. Define BITTY_SEQ_TRACE_EN to print retire/halt/error trace lines.
module bitty_fetch_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                TIMEOUT     = 15,
    parameter logic [15:0]       HALT_OPCODE = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic              en_i,
    output logic              en_s,
    output logic              en_c,
    input  logic              core_done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_LOAD,
        S_CALC,
        S_WAIT_DONE,
        S_ADVANCE,
        S_HALTED,
        S_ERROR
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] tmo_cnt;
    logic       single_step;
    logic       tmo_hit;

    // The counter value being written this cycle is the number of WAIT_DONE cycles spent so far,
    // so the watchdog trips on the TIMEOUT-th cycle rather than one later.
    assign tmo_hit = (tmo_cnt + 8'd1) == TMO_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            retired     <= 16'h0000;
            tmo_cnt     <= 8'd0;
            single_step <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run || step) begin
                        state       <= S_FETCH;
                        single_step <= step;
                    end
                end
                S_FETCH:    state <= S_WAIT_MEM;
                S_WAIT_MEM: begin
                    instr <= imem_rdata;
                    state <= (imem_rdata == HALT_OPCODE) ? S_HALTED : S_ISSUE;
                end
                S_ISSUE:    state <= S_LOAD;
                S_LOAD:     state <= S_CALC;
                S_CALC: begin
                    tmo_cnt <= 8'd0;
                    state   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (core_done) begin
                        state <= S_ADVANCE;
                    end else if (tmo_hit) begin
                        state <= S_ERROR;
                    end
                end
                S_ADVANCE: begin
                    pc <= pc + 1'b1;
                    if (retired != 16'hFFFF) begin
                        retired <= retired + 16'd1;
                    end
                    if (run && !single_step) begin
                        state <= S_FETCH;
                    end else begin
                        state       <= S_IDLE;
                        single_step <= 1'b0;
                    end
                end
                S_HALTED:   state <= S_HALTED;
                S_ERROR:    state <= S_ERROR;
                default:    state <= S_IDLE;
            endcase
        end
    end

    assign imem_rd     = (state == S_FETCH);
    assign imem_addr   = pc;
    assign en_i        = (state == S_ISSUE);
    assign en_s        = (state == S_LOAD);
    assign en_c        = (state == S_CALC);
    assign halted      = (state == S_HALTED);
    assign timeout_err = (state == S_ERROR);
    assign busy        = !((state == S_IDLE) || (state == S_HALTED) || (state == S_ERROR));

`ifdef BITTY_SEQ_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_ADVANCE) begin
                $display("RETIRE pc=%0d instr=%h n=%0d", pc, instr, retired + 16'd1);
            end
            if ((state == S_WAIT_MEM) && (imem_rdata == HALT_OPCODE)) begin
                $display("HALTED pc=%0d", pc);
            end
            if ((state == S_WAIT_DONE) && !core_done && tmo_hit) begin
                $display("ERROR timeout pc=%0d instr=%h", pc, instr);
            end
        end
    end
`else
    // Trace output compiled out.
`endif

endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// Bench for bitty_fetch_sequencer: directed handshake/boundary steps plus randomized programs
// checked against a retirement-count model of the sequencer.
module tb_bitty_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, run, step, run_b;
    logic        imem_rd, en_i, en_s, en_c, core_done, busy, halted, timeout_err;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_rdata, instr, retired;

    logic        imem_rd_b, en_i_b, en_s_b, en_c_b, core_done_b, busy_b, halted_b, timeout_err_b;
    logic [1:0]  imem_addr_b, pc_b;
    logic [15:0] imem_rdata_b, instr_b, retired_b;

    bitty_fetch_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .en_i(en_i), .en_s(en_s), .en_c(en_c), .core_done(core_done),
        .pc(pc), .retired(retired), .busy(busy), .halted(halted), .timeout_err(timeout_err)
    );

    bitty_fetch_sequencer #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .run(run_b), .step(1'b0),
        .imem_rd(imem_rd_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .instr(instr_b), .en_i(en_i_b), .en_s(en_s_b), .en_c(en_c_b), .core_done(core_done_b),
        .pc(pc_b), .retired(retired_b), .busy(busy_b), .halted(halted_b), .timeout_err(timeout_err_b)
    );

    // Synchronous instruction memories.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [4];
    always @(posedge clk) if (imem_rd) imem_rdata <= mem_a[imem_addr];
    always @(posedge clk) if (imem_rd_b) imem_rdata_b <= mem_b[imem_addr_b];

    // Core models: core_done rises done_lat cycles after the en_c capture (0 = never).
    int   done_lat = 2;
    logic spur = 1'b0;
    logic core_act;
    int   core_wc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_act <= 1'b0; core_wc <= 0;
        end else if (en_c) begin
            core_act <= 1'b1; core_wc <= 1;
        end else if (core_done) begin
            core_act <= 1'b0;
        end else if (core_act) begin
            core_wc <= core_wc + 1;
        end
    end
    assign core_done = spur || (core_act && (done_lat != 0) && (core_wc == done_lat));

    logic core_act_b;
    int   core_wc_b;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_act_b <= 1'b0; core_wc_b <= 0;
        end else if (en_c_b) begin
            core_act_b <= 1'b1; core_wc_b <= 1;
        end else if (core_done_b) begin
            core_act_b <= 1'b0;
        end else if (core_act_b) begin
            core_wc_b <= core_wc_b + 1;
        end
    end
    assign core_done_b = core_act_b && (core_wc_b == 2);

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: every captured instruction with a responsive core retires, so the
    // expected pc is simply the retirement count since reset; a fetch of the halt word halts.
    int exp_ret = 0;
    bit exp_halt = 1'b0;
    int n_fetch = 0, n_i = 0, n_s = 0, n_c = 0;
    always @(posedge reset) begin
        exp_ret  = 0;
        exp_halt = 1'b0;
    end
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_rd) begin
                n_fetch++;
                check("fetch_addr", imem_addr, exp_ret[7:0]);
                if (mem_a[imem_addr] == 16'hFFFF) exp_halt = 1'b1;
            end
            if (en_i) begin
                n_i++;
                check("issue_instr", instr, mem_a[exp_ret[7:0]]);
            end
            if (en_s) n_s++;
            if (en_c) begin
                n_c++;
                if (done_lat != 0) exp_ret++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        run = 1'b0; step = 1'b0; run_b = 1'b0; spur = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < bound);
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic wait_strobe(input bit want_c, input int bound);
        int n;
        n = 0;
        while (!(want_c ? en_c : en_s) && n < bound) begin
            tick();
            n++;
        end
        check(want_c ? "en_c_seen" : "en_s_seen", want_c ? en_c : en_s, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, f0, c0, k, t, hk;
        int fq[$];
        logic [1:0] bq[$];

        for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
        for (int i = 0; i < 4; i++) mem_b[i] = 16'(i * 16'h0111 + 16'h0100);
        run = 1'b0; step = 1'b0; run_b = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_pc", pc, 0);
        check("rst_retired", retired, 0);
        check("rst_instr", instr, 0);
        check("rst_strobes", {imem_rd, en_i, en_s, en_c}, 4'b0000);
        check("rst_flags", {busy, halted, timeout_err}, 3'b000);
        tick(); tick();
        reset = 1'b0;

        // Two instructions then halt at pc=2, free-running.
        mem_a[0] = 16'h2041; mem_a[1] = 16'h4082; mem_a[2] = 16'hFFFF;
        c0 = n_c;
        run = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (imem_rd) fq.push_back(i);
            if (halted) break;
        end
        check("t1_fetches", fq.size(), 3);
        if (fq.size() == 3) begin
            check("t1_lat0", fq[1] - fq[0], 8);
            check("t1_lat1", fq[2] - fq[1], 8);
        end
        check("t1_en_c", n_c - c0, 2);
        check("t1_en_i_en_s", {n_i, n_s}, {32'd2, 32'd2});
        tick(); tick();
        check("t1_halted", halted, 1'b1);
        check("t1_retired", retired, 2);
        check("t1_pc", pc, 2);
        check("t1_busy", busy, 1'b0);
        check("t1_instr", instr, 16'hFFFF);

        // Single-step, spurious core_done while idle, step ignored while busy.
        do_reset();
        mem_a[2] = 16'h1234;
        spur = 1'b1;
        tick(); tick(); tick();
        spur = 1'b0;
        check("spur_ignored", {pc, retired, 7'd0, busy}, 32'd0);
        pulse_step();
        wait_idle(50, n);
        check("step1_cycles", n + 1, 9);
        check("step1_pc", pc, 1);
        check("step1_retired", retired, 1);
        pulse_step();
        tick(); tick();
        pulse_step();
        wait_idle(50, n);
        tick(); tick();
        check("step2_pc", pc, 2);
        check("step2_retired", retired, 2);

        // run and step together behave as a single step even with run held through ADVANCE.
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("runstep_idle", busy, 1'b0);
        run = 1'b0;
        tick();
        check("runstep_pc", pc, 3);

        // run dropped during LOAD: the instruction still finishes.
        c0 = n_c;
        run = 1'b1;
        wait_strobe(1'b0, 20);
        run = 1'b0;
        wait_idle(50, n);
        check("drop_en_c", n_c - c0, 1);
        check("drop_pc", pc, 4);
        check("drop_retired", retired, 4);

        // Watchdog: core never answers.
        do_reset();
        done_lat = 0;
        pulse_step();
        wait_strobe(1'b1, 20);
        k = 0;
        do begin
            tick();
            k++;
        end while (!timeout_err && k < 40);
        check("tmo_cycles", k, 16);
        check("tmo_flags", {busy, halted, timeout_err}, 3'b001);
        f0 = n_fetch;
        run = 1'b1;
        pulse_step();
        for (int i = 0; i < 10; i++) tick();
        run = 1'b0;
        check("tmo_sticky", timeout_err, 1'b1);
        check("tmo_no_fetch", n_fetch - f0, 0);
        check("tmo_pc", {pc, retired}, 24'd0);

        // core_done on the exact cycle the watchdog would trip: done wins.
        do_reset();
        done_lat = 15;
        pulse_step();
        wait_idle(60, n);
        check("done_wins_err", timeout_err, 1'b0);
        check("done_wins_ret", {pc, retired}, {8'd1, 16'd1});

        // Reset asserted during CALC, then refetch from RESET_PC.
        do_reset();
        done_lat = 2;
        run = 1'b1;
        wait_strobe(1'b1, 20);
        reset = 1'b1;
        #1;
        check("rstcalc_pc_ret", {pc, retired}, 24'd0);
        check("rstcalc_instr", instr, 0);
        check("rstcalc_out", {imem_rd, en_i, en_s, en_c, busy, halted, timeout_err}, 7'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rstcalc_refetch", {imem_rd, imem_addr}, {1'b1, 8'd0});
        run = 1'b0;
        wait_idle(50, n);

        // Narrow PC wraps 3 -> 0.
        do_reset();
        run_b = 1'b1;
        t = 0;
        while (t < 80) begin
            tick();
            t++;
            if (imem_rd_b) begin
                bq.push_back(imem_addr_b);
                if (bq.size() == 5) run_b = 1'b0;
            end
            if (!busy_b && t > 1) break;
        end
        check("wrap_cycles", t, 5 * 8 + 1);
        check("wrap_fetches", bq.size(), 5);
        if (bq.size() == 5)
            check("wrap_seq", {bq[0], bq[1], bq[2], bq[3], bq[4]}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        check("wrap_retired", retired_b, 5);
        check("wrap_pc", pc_b, 1);

        // Randomized programs with a halt word and random run/step traffic.
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            for (int i = 0; i < 32; i++) mem_a[i] = 16'($urandom_range(0, 16'hFFFE));
            hk = $urandom_range(4, 14);
            mem_a[hk] = 16'hFFFF;
            for (int op = 0; op < 12; op++) begin
                done_lat = $urandom_range(1, 15);
                if ($urandom_range(0, 1) == 0) begin
                    pulse_step();
                end else begin
                    run = 1'b1;
                    n = $urandom_range(1, 30);
                    for (int i = 0; i < n; i++) tick();
                    run = 1'b0;
                end
                wait_idle(200, n);
                check("rand_pc", pc, exp_ret[7:0]);
                check("rand_retired", retired, exp_ret);
                check("rand_halted", halted, exp_halt);
                check("rand_err", timeout_err, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitty_fetch_sequencer.md
Name: bitty_fetch_sequencer

Overview:
- Instruction sequencer for the Bitty execution core.
- Holds the program counter and fetches 16-bit instructions from a synchronous instruction memory.
- Presents each instruction to the core and steps the core through its IDLE→LOAD→CALC→STORE→DONE handshake by driving en_i/en_s/en_c.
- Waits for core_done, then retires the instruction and advances the PC. Supports free-run, single-step, a halt opcode and a done-timeout watchdog.

Parameters:
- ADDR_W, 8, instruction memory address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, maximum WAIT_DONE cycles before the watchdog trips; legal range 2..255.
- HALT_OPCODE, 16'hFFFF, instruction word that stops sequencing.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; while high, fetch instructions back-to-back.
- step  input  1  one-cycle pulse; execute exactly one instruction when in IDLE.
- imem_rd  output  1  instruction memory read strobe.
- imem_addr  output  ADDR_W  instruction memory address; equals pc.
- imem_rdata  input  16  read data, valid the cycle after imem_rd.
- instr  output  16  registered instruction word driven to the core.
- en_i  output  1  core instruction-load enable.
- en_s  output  1  core source-load enable.
- en_c  output  1  core result-capture enable.
- core_done  input  1  core DONE-state indicator.
- pc  output  ADDR_W  current program counter.
- retired  output  16  retired-instruction count, saturates at 16'hFFFF.
- busy  output  1  high in any state other than IDLE, HALTED or ERROR.
- halted  output  1  high in HALTED.
- timeout_err  output  1  high in ERROR.

Behaviour:
- Reset (async) values:
  - state = IDLE, pc = RESET_PC, instr = 0, retired = 0, timeout counter = 0.
  - All strobes low; busy, halted and timeout_err all 0.
- Strobes are Moore outputs decoded from state. Each strobe is high for exactly one cycle per instruction.
- States and transitions:
  - IDLE → FETCH if run or step; otherwise stay. When entered from step, the single-step flag is set.
  - FETCH: imem_rd=1, imem_addr=pc. → WAIT_MEM.
  - WAIT_MEM: instr <= imem_rdata. If imem_rdata == HALT_OPCODE → HALTED; else → ISSUE.
  - ISSUE: en_i=1. → LOAD.
  - LOAD: en_s=1. → CALC.
  - CALC: en_c=1; clear the timeout counter. → WAIT_DONE.
  - WAIT_DONE: increment the timeout counter each cycle. If core_done → ADVANCE. Else if counter == TIMEOUT → ERROR.
  - ADVANCE: pc <= pc+1 (wraps to 0 after 2^ADDR_W−1); retired <= retired+1 (saturating). Then:
    - → FETCH if run is high and the single-step flag is clear;
    - else → IDLE, clearing the single-step flag.
  - HALTED: pc frozen at the halt address; retired not incremented. Exits only via reset.
  - ERROR: sticky; exits only via reset.
- Latency: nominal instruction takes 8 cycles, from FETCH entry to the next FETCH/IDLE. WAIT_DONE lasts 2 cycles with a compliant core.
- Simultaneous events and boundary conditions:
  - run and step both high in IDLE → treated as step: one instruction, then IDLE.
  - step pulses outside IDLE are ignored.
  - run falling mid-instruction → the current instruction completes through ADVANCE, then IDLE. The core is never left mid-handshake.
  - core_done asserted outside WAIT_DONE is ignored.
  - core_done arriving in the same cycle the counter reaches TIMEOUT → ADVANCE; done wins.
  - reset mid-instruction → immediate return to reset values. The core is reset by the same reset.
  - pc wrap: at pc = 2^ADDR_W−1, ADVANCE yields 0 with no error.

Optional Feature:
- Macro: BITTY_SEQ_TRACE_EN.
- With the macro defined: in each ADVANCE cycle, a simulation $display prints "RETIRE pc=<pc> instr=<hex> n=<retired+1>". Entry to HALTED and entry to ERROR each print one line.
- Without the macro: no display code is compiled.
- Ports and cycle behaviour are identical in both builds.

Test Plan:
- Reset, memory at 0..2 = 16'h2041, 16'h4082, 16'hFFFF, run=1 → two instructions of 8 cycles each, en_i/en_s/en_c one pulse each per instruction. Halt at pc=2: halted=1, retired=2, pc=2.
- run=0, one step pulse, memory[0]=16'h2041 → exactly one instruction; back to IDLE with pc=1, retired=1, busy=0. A second step pulse gives pc=2.
- Core model holds core_done low, TIMEOUT=15 → ERROR entered after 15 WAIT_DONE cycles with timeout_err=1. Then run and step are ignored until reset.
- ADDR_W=2, run=1, no halt opcode → pc sequence 0,1,2,3,0; retired=5 after 5 instructions (40 cycles).
- run dropped during the LOAD state → en_c still pulses and ADVANCE occurs; then IDLE with pc incremented by 1.
- reset asserted during CALC → all outputs at reset values in the same cycle. Releasing reset with run=1 refetches from RESET_PC.
